// File: rtl/lsb_serializer_pkg.sv
// Shared types and constants for the LSB-first serializer.
package lsb_serializer_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/lsb_shreg.sv
// Shift register with bit counter: captures a word, then emits it LSB first
// through a registered output bit together with a registered last-bit flag.
module lsb_shreg
   import lsb_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_advance,
   input  logic             i_first,
   input  logic             i_clear,
   output logic             o_bit,
   output logic             o_last
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_bit;
   logic             r_last;
   logic [CW-1:0]    w_cnt_nxt;

   // The first advance (leaving CLR) presents bit 0, so the count restarts there.
   assign w_cnt_nxt = i_first ? '0 : r_cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sh   <= '0;
         r_cnt  <= '0;
         r_bit  <= 1'b0;
         r_last <= 1'b0;
      end else if (i_load) begin
         r_sh   <= i_data;
         r_cnt  <= '0;
         r_bit  <= 1'b0;
         r_last <= 1'b0;
      end else if (i_advance) begin
         r_bit  <= r_sh[0];
         r_sh   <= {1'b0, r_sh[WIDTH-1:1]};
         r_cnt  <= w_cnt_nxt;
         r_last <= (w_cnt_nxt == LAST_CNT);
      end else if (i_clear) begin
         r_bit  <= 1'b0;
         r_last <= 1'b0;
      end
   end

   assign o_bit  = r_bit;
   assign o_last = r_last;
endmodule

// File: rtl/lsb_serializer.sv
// Parallel-to-serial converter, LSB first, with a one-cycle frame_clr pulse
// ahead of every word to reset the downstream serial stage.
module lsb_serializer
   import lsb_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             out,
   output logic             bit_valid,
   output logic             bit_last,
   output logic             frame_clr
);
   state_t r_state;
   logic   r_bit_valid;
   logic   r_frame_clr;
   logic   w_last;
   logic   w_final;
   logic   w_accept;
   logic   w_advance;

   // Ready on the final bit lets back-to-back words share a single CLR gap.
   assign w_final    = (r_state == SHIFT) && w_last;
   assign load_ready = !reset && ((r_state == IDLE) || w_final);
   assign w_accept   = load_valid && load_ready;
   assign w_advance  = (r_state == CLR) || ((r_state == SHIFT) && !w_last);

   lsb_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_accept),
      .i_data    (data_in),
      .i_advance (w_advance),
      .i_first   (r_state == CLR),
      .i_clear   (w_final),
      .o_bit     (out),
      .o_last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_bit_valid <= 1'b0;
         r_frame_clr <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state     <= CLR;
                  r_frame_clr <= 1'b1;
               end
            end
            CLR: begin
               r_state     <= SHIFT;
               r_frame_clr <= 1'b0;
               r_bit_valid <= 1'b1;
            end
            SHIFT: begin
               if (w_last) begin
                  r_bit_valid <= 1'b0;
                  if (w_accept) begin
                     r_state     <= CLR;
                     r_frame_clr <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_bit_valid <= 1'b0;
               r_frame_clr <= 1'b0;
            end
         endcase
      end
   end

   assign bit_valid = r_bit_valid;
   assign bit_last  = w_last;
   assign frame_clr = r_frame_clr;
endmodule

// File: doc/lsb_serializer.md
LSB_SERIALIZER -- requirements
Module: lsb_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  WIDTH  parallel word to serialize, bit 0 = LSB.
REQ-005 SHALL have port load_valid  input  1  data_in holds a word offered for loading.
REQ-006 SHALL have port load_ready  output  1  block accepts data_in this cycle.
REQ-007 SHALL have port out  output  1  serial data bit, LSB first; feeds the downstream serial two's-complement stage.
REQ-008 SHALL have port bit_valid  output  1  out carries a valid word bit.
REQ-009 SHALL have port bit_last  output  1  out carries bit WIDTH-1 of the word.
REQ-010 SHALL have port frame_clr  output  1  one-cycle pulse; drives the downstream stage's reset input ahead of each word.

Function
REQ-011 SHALL implement states IDLE, CLR and SHIFT.
REQ-012 SHALL accept a word at a posedge where load_valid and load_ready are both 1, capturing data_in into a WIDTH-bit shift register.
REQ-013 SHALL drive load_ready = 1 in IDLE, or in SHIFT while the final bit (count = WIDTH-1) is presented; 0 otherwise, and 0 whenever reset = 1.
REQ-014 SHALL move from IDLE or final-bit SHIFT to CLR on accept; with no accept, final-bit SHIFT SHALL return to IDLE.
REQ-015 SHALL hold frame_clr = 1, bit_valid = 0, out = 0 for exactly one cycle in CLR, then go to SHIFT with count = 0.
REQ-016 SHALL present bit k of the captured word on out with bit_valid = 1 during SHIFT count k, k = 0..WIDTH-1, one bit per cycle.
REQ-017 SHALL assert bit_last only during count = WIDTH-1.
REQ-018 Latency: accept at edge E0 -> frame_clr after E0 -> bit 0 after E1 -> bit WIDTH-1 after E_WIDTH.
REQ-019 SHALL insert back-to-back words with exactly one CLR cycle between the last bit of one word and bit 0 of the next. No other idle cycle is allowed.
REQ-020 SHALL ignore data_in and load_valid whenever load_ready = 0. A held word is neither dropped nor duplicated.
REQ-021 SHALL register all outputs except load_ready, with no combinational path from data_in to out.
REQ-022 SHALL use a bit counter of clog2(WIDTH) bits that never exceeds WIDTH-1.

Reset
REQ-023 On reset: state = IDLE, count = 0, shift register = 0, out = 0, bit_valid = 0, bit_last = 0, frame_clr = 0.
REQ-024 Reset mid-SHIFT or mid-CLR SHALL abort the word; no further bits of that word SHALL appear.
REQ-025 load_valid during a reset cycle SHALL NOT be accepted.
REQ-026 After reset deasserts, load_ready SHALL be 1 in the first cycle.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, CLR, SHIFT) and the default WIDTH constant.
REQ-028 The shift register with its bit counter SHALL be one sub-module, lsb_shreg (load, shift, count, last flag). The FSM and handshake SHALL stay in lsb_serializer.

Verification
REQ-029 Case 1: WIDTH=8, accept 8'hB4 -> frame_clr 1 cycle, then out = 0,0,1,0,1,1,0,1 with bit_valid=1 and bit_last only on the 8th bit.
REQ-030 Case 2: cascade out/frame_clr into the downstream two's-complement stage; word 8'hB4 -> downstream stream 0,0,1,1,0,0,1,0 (8'h4C) after its one-cycle latency.
REQ-031 Case 3: load_valid held high with 8'h01 then 8'hFF -> accept on final-bit cycle; exactly one CLR cycle between words; second word out = eight 1s.
REQ-032 Case 4: reset asserted on the 3rd bit of 8'hAA -> the next cycle has out=0, bit_valid=0, state IDLE; load_ready=1 after release; 8'h55 then serializes correctly.
REQ-033 Case 5: load_valid toggled while in SHIFT with 8'h0F -> no accept until the final-bit cycle; the 8'h0F stream is unaffected.
REQ-034 Case 6: WIDTH=2, accept 2'b10 -> out 0 then 1, bit_last on the 2nd bit; the counter never exceeds 1.
